// File: rtl/reg_access_master.sv
// Command-driven initiator for a registered-read register file: single writes, burst reads.
// Define REG_ACCESS_WRITE_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module reg_access_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data_in,
  input  logic [DATA_W-1:0] reg_data_out,
  output logic              busy
);

  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] bcnt_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WW-1:0]     wcnt_q;
  logic              last_beat;

  assign last_beat = (bcnt_q == '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (cmd_valid) state_nx = cmd_write ? WRITE : RD_ISSUE;
      WRITE:
`ifdef REG_ACCESS_WRITE_VERIFY_EN
        state_nx = RD_ISSUE;
`else
        state_nx = RESP;
`endif
      RD_ISSUE:
        state_nx = RD_WAIT;
      RD_WAIT:
        if (wcnt_q == '0) state_nx = RESP;
      RESP:
        if (rsp_ready) state_nx = last_beat ? IDLE : RD_ISSUE;
      default:
        state_nx = IDLE;
    endcase
  end

`ifdef REG_ACCESS_WRITE_VERIFY_EN
  logic wr_q;
  logic err_q;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_q  <= '0;
      bcnt_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
`ifdef REG_ACCESS_WRITE_VERIFY_EN
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE:
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            // writes are always a single beat
            bcnt_q <= cmd_write ? '0 : cmd_len;
            if (cmd_write) wdata_q <= cmd_wdata;
`ifdef REG_ACCESS_WRITE_VERIFY_EN
            wr_q   <= cmd_write;
            err_q  <= 1'b0;
`endif
          end
        WRITE:
          rdata_q <= '0;
        RD_ISSUE:
          wcnt_q <= WW'(RD_LAT - 1);
        RD_WAIT:
          if (wcnt_q == '0) begin
            rdata_q <= reg_data_out;
`ifdef REG_ACCESS_WRITE_VERIFY_EN
            err_q   <= wr_q && (reg_data_out != wdata_q);
`endif
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        RESP:
          if (rsp_ready && !last_beat) begin
            bcnt_q <= bcnt_q - 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign reg_wr_en   = (state == WRITE);
  assign reg_rd_en   = (state == RD_ISSUE);
  assign reg_addr    = addr_q;
  assign reg_data_in = wdata_q;
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_addr    = addr_q;
  assign rsp_last    = (state == RESP) && last_beat;

`ifdef REG_ACCESS_WRITE_VERIFY_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master with a behavioural 16x8 register file.
// Honours REG_ACCESS_WRITE_VERIFY_EN when the design is built with it.
module tb_reg_access_master;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RL = 2;
`ifdef REG_ACCESS_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int WLAT = VFY ? RL + 2 : 1;

  logic          clk = 1'b0;
  logic          nreset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          rsp_err;
  logic          reg_wr_en;
  logic          reg_rd_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data_in;
  logic [DW-1:0] reg_data_out;
  logic          busy;

  always #5 clk = ~clk;

  reg_access_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .busy(busy)
  );

  // register file: data valid RL-1 edges after the sampling edge
  logic [DW-1:0] mem [16];
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] q2 = '0;
  logic          corrupt = 1'b0;

  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_data_in;
    if (reg_rd_en) q1 <= mem[reg_addr];
    q2 <= q1;
  end
  assign reg_data_out = corrupt ? '0 : q2;

  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   viol = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  always @(posedge clk) begin
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (reg_wr_en) wr_cnt <= wr_cnt + 1;
    if ((reg_rd_en && reg_wr_en) || (reg_rd_en && prev_rd) ||
        (reg_wr_en && prev_wr))
      viol <= viol + 1;
    prev_rd <= reg_rd_en;
    prev_wr <= reg_wr_en;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a,
                       input logic [AW-1:0] l, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_wdata = d;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 64);
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n;
    int wc0;
    int r0;
    bit stable;
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          sl;

    tbl[0]  = '{1'b1, 4'd3,  8'hA5, 8'h00};
    tbl[1]  = '{1'b0, 4'd3,  8'h00, 8'hA5};
    tbl[2]  = '{1'b1, 4'd14, 8'h11, 8'h00};
    tbl[3]  = '{1'b1, 4'd15, 8'h22, 8'h00};
    tbl[4]  = '{1'b1, 4'd0,  8'h33, 8'h00};
    tbl[5]  = '{1'b1, 4'd1,  8'h44, 8'h00};
    tbl[6]  = '{1'b0, 4'd15, 8'h00, 8'h22};
    tbl[7]  = '{1'b0, 4'd0,  8'h00, 8'h33};
    tbl[8]  = '{1'b1, 4'd7,  8'hFF, 8'h00};
    tbl[9]  = '{1'b0, 4'd7,  8'h00, 8'hFF};
    tbl[10] = '{1'b1, 4'd7,  8'h00, 8'h00};
    tbl[11] = '{1'b0, 4'd7,  8'h00, 8'h00};
    for (int i = 0; i < 12; i++)
      if (tbl[i].wr) tbl[i].exp_rdata = VFY ? tbl[i].wdata : 8'h00;
    ea = '{4'd14, 4'd15, 4'd0, 4'd1};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};

    // power-on reset
    #2 nreset = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;

    // single-beat table
    for (int i = 0; i < 12; i++) begin
      wc0 = wr_cnt;
      issue(tbl[i].wr, tbl[i].addr, 4'd0, tbl[i].wdata);
      if (tbl[i].wr) begin
        chk($sformatf("v%0d_wr_en", i), 32'(reg_wr_en), 1);
        chk($sformatf("v%0d_wdata", i), 32'(reg_data_in), 32'(tbl[i].wdata));
      end else begin
        chk($sformatf("v%0d_rd_en", i), 32'(reg_rd_en), 1);
      end
      chk($sformatf("v%0d_reg_addr", i), 32'(reg_addr), 32'(tbl[i].addr));
      wait_rsp(n);
      chk($sformatf("v%0d_latency", i), 32'(n), tbl[i].wr ? WLAT : RL + 1);
      chk($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(tbl[i].exp_rdata));
      chk($sformatf("v%0d_addr", i), 32'(rsp_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_last", i), 32'(rsp_last), 1);
      chk($sformatf("v%0d_err", i), 32'(rsp_err), 0);
      handshake();
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
      chk($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt - wc0), tbl[i].wr ? 1 : 0);
    end

    // wrapping burst
    issue(1'b0, 4'd14, 4'd3, 8'h00);
    for (int b = 0; b < 4; b++) begin
      wait_rsp(n);
      chk($sformatf("wrap%0d_addr", b), 32'(rsp_addr), 32'(ea[b]));
      chk($sformatf("wrap%0d_data", b), 32'(rsp_rdata), 32'(ed[b]));
      chk($sformatf("wrap%0d_last", b), 32'(rsp_last), (b == 3) ? 1 : 0);
      handshake();
    end
    chk("wrap_idle", 32'(busy), 0);

    // same burst under back-pressure
    r0 = rd_cnt;
    issue(1'b0, 4'd14, 4'd3, 8'h00);
    for (int b = 0; b < 4; b++) begin
      wait_rsp(n);
      sa = rsp_addr;
      sd = rsp_rdata;
      sl = rsp_last;
      wc0 = rd_cnt;
      stable = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_addr != sa || rsp_rdata != sd || rsp_last != sl)
          stable = 1'b0;
      end
      chk($sformatf("bp%0d_stable", b), 32'(stable), 1);
      chk($sformatf("bp%0d_no_rd", b), 32'(rd_cnt - wc0), 0);
      chk($sformatf("bp%0d_addr", b), 32'(rsp_addr), 32'(ea[b]));
      chk($sformatf("bp%0d_data", b), 32'(rsp_rdata), 32'(ed[b]));
      chk($sformatf("bp%0d_last", b), 32'(rsp_last), (b == 3) ? 1 : 0);
      handshake();
    end
    chk("bp_rd_pulses", 32'(rd_cnt - r0), 4);

    // command held while busy
    issue(1'b0, 4'd3, 4'd0, 8'h00);
    cmd_valid = 1'b1;
    cmd_addr  = 4'd14;
    stable = 1'b1;
    n = 0;
    while (!rsp_valid && n < 64) begin
      if (cmd_ready) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("busy_no_ready", 32'(stable), 1);
    chk("busy_rsp1_data", 32'(rsp_rdata), 32'hA5);
    handshake();
    cmd_valid = 1'b1;
    chk("busy_ready_again", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_accept_rd", 32'(reg_rd_en), 1);
    chk("busy_accept_addr", 32'(reg_addr), 14);
    wait_rsp(n);
    chk("busy_rsp2_data", 32'(rsp_rdata), 32'h11);
    handshake();

`ifdef REG_ACCESS_WRITE_VERIFY_EN
    corrupt = 1'b1;
    issue(1'b1, 4'd5, 4'd0, 8'h5A);
    wait_rsp(n);
    chk("vfy_bad_err", 32'(rsp_err), 1);
    chk("vfy_bad_data", 32'(rsp_rdata), 32'h00);
    handshake();
    corrupt = 1'b0;
    issue(1'b1, 4'd5, 4'd0, 8'h5A);
    wait_rsp(n);
    chk("vfy_ok_err", 32'(rsp_err), 0);
    chk("vfy_ok_data", 32'(rsp_rdata), 32'h5A);
    handshake();
`endif

    // reset in the middle of a burst
    issue(1'b0, 4'd14, 4'd3, 8'h00);
    @(posedge clk); #1;
    chk("mid_in_wait", 32'({busy, reg_rd_en}), 32'b10);
    nreset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rsp", 32'({rsp_valid, rsp_last, rsp_err}), 0);
    chk("mid_rdata", 32'(rsp_rdata), 0);
    chk("mid_reg", 32'({reg_wr_en, reg_rd_en, reg_addr, reg_data_in}), 0);
    @(posedge clk); #1;
    nreset = 1'b1;
    stable = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) stable = 1'b0;
    end
    chk("mid_no_stale", 32'(stable), 1);

    chk("strobe_rules", 32'(viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
